// File: rtl/game_event_bridge.sv
// Game-side bridge: queues scoring events, posts them to CPU r29 with a toggle handshake on r1[0],
// and decodes r1 into level/pause/game-over controls. Define GAME_EVENT_STATS_EN to add ev_drop_count.
module game_event_bridge #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 8
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ev_valid,
  input  logic [2:0]  ev_points,
  output logic        ev_ready,
  input  logic        game_over,
  output logic [2:0]  addPoints,
  output logic [1:0]  fromGame,
  input  logic [31:0] data_readReg1,
  output logic [7:0]  cpu_level,
  output logic        cpu_pause,
  output logic        ev_overflow,
  output logic        ack_timeout
`ifdef GAME_EVENT_STATS_EN
  ,
  output logic [15:0] ev_drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, POST, WAIT_ACK, GAP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic [2:0]    pts_q, pts_d;
  logic          post_q, post_d;
  logic          ack_ref_q, ack_ref_d;
  logic [31:0]   timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          go_q, r1b1_q;
  logic [7:0]    level_q;
  logic          pause_q, ovf_q, tmo_q;

  logic full, empty, push, drop, ack, tmo_hit, pop, tmo;
  logic unused_r1;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = ev_valid && !full && (ev_points != 3'd0);
  // zero-point events are never counted as lost, even when the queue is full
  assign drop    = ev_valid && full && (ev_points != 3'd0);
  assign ack     = (data_readReg1[0] != ack_ref_q);
  assign tmo_hit = (timer_q == 32'(TIMEOUT_CYCLES - 1));
  assign pop     = (state_q == WAIT_ACK) && (ack || tmo_hit);
  assign tmo     = (state_q == WAIT_ACK) && !ack && tmo_hit;
  assign unused_r1 = ^{data_readReg1[31:16], data_readReg1[7:3]};

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= ev_points;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q   <= IDLE;
      pts_q     <= '0;
      post_q    <= 1'b0;
      ack_ref_q <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pts_q     <= pts_d;
      post_q    <= post_d;
      ack_ref_q <= ack_ref_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!empty) state_d = POST;
      POST:     state_d = WAIT_ACK;
      WAIT_ACK: if (pop) state_d = GAP;
      GAP:      if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
    endcase
  end

  // r29 value and strobe are registered so they stay glitch-free across the regfile reload
  always_comb begin
    pts_d     = pts_q;
    post_d    = post_q;
    ack_ref_d = ack_ref_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    case (state_q)
      POST: begin
        pts_d     = mem_q[rd_q];
        post_d    = 1'b1;
        ack_ref_d = data_readReg1[0];
        timer_d   = '0;
      end
      WAIT_ACK: begin
        timer_d = timer_q + 32'd1;
        if (pop) begin
          pts_d  = '0;
          post_d = 1'b0;
          gap_d  = '0;
        end
      end
      GAP:     gap_d = gap_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      go_q    <= 1'b0;
      r1b1_q  <= 1'b0;
      level_q <= '0;
      pause_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      // a coincident game_over pulse outranks the r1[1] clear edge
      go_q    <= game_over | (go_q & ~(data_readReg1[1] & ~r1b1_q));
      r1b1_q  <= data_readReg1[1];
      level_q <= data_readReg1[15:8];
      pause_q <= data_readReg1[2];
      if (drop) ovf_q <= 1'b1;
      if (tmo)  tmo_q <= 1'b1;
    end
  end

`ifdef GAME_EVENT_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;
  assign drop_sum = 17'(drop_cnt_q) + 17'(drop) + 17'(tmo);
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign ev_drop_count = drop_cnt_q;
`endif

  assign ev_ready    = !full;
  assign addPoints   = pts_q;
  assign fromGame    = {go_q, post_q};
  assign cpu_level   = level_q;
  assign cpu_pause   = pause_q;
  assign ev_overflow = ovf_q;
  assign ack_timeout = tmo_q;

endmodule

// File: tb/tb_game_event_bridge.sv
// Scoreboard bench for game_event_bridge: expected posts queued on push, popped when fromGame[0] rises.
module tb_game_event_bridge;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int GAP   = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic [2:0]  ev_points = '0;
  logic        ev_ready;
  logic        game_over = 1'b0;
  logic [2:0]  addPoints;
  logic [1:0]  fromGame;
  logic [31:0] r1 = '0;
  logic [7:0]  cpu_level;
  logic        cpu_pause;
  logic        ev_overflow;
  logic        ack_timeout;
`ifdef GAME_EVENT_STATS_EN
  logic [15:0] ev_drop_count;
`endif

  game_event_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ev_valid(ev_valid), .ev_points(ev_points),
    .ev_ready(ev_ready), .game_over(game_over), .addPoints(addPoints), .fromGame(fromGame),
    .data_readReg1(r1), .cpu_level(cpu_level), .cpu_pause(cpu_pause),
    .ev_overflow(ev_overflow), .ack_timeout(ack_timeout)
`ifdef GAME_EVENT_STATS_EN
    , .ev_drop_count(ev_drop_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] sb[$];
  logic       exp_ovf = 1'b0;
  logic       exp_to = 1'b0;
  int         exp_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // monitor: sampled 1 time unit after each active edge
  logic       mon_prev = 1'b0;
  logic       mon_pend = 1'b0;
  logic [2:0] mon_cur = '0;
  int         mon_low = 0;
  always @(posedge clock) begin
    #1;
    if (ctrl_reset) begin
      mon_prev = 1'b0;
      mon_pend = 1'b0;
    end else begin
      if (fromGame[0] && !mon_prev) begin
        if (sb.size() == 0) chk("spurious_post", 32'(fromGame[0]), 32'd0);
        else begin
          mon_cur = sb.pop_front();
          chk("post_pts", 32'(addPoints), 32'(mon_cur));
        end
        if (mon_pend) chk("gap_len", mon_low, GAP + 2);
        mon_pend = 1'b0;
      end else if (fromGame[0]) begin
        chk("hold_pts", 32'(addPoints), 32'(mon_cur));
      end else begin
        chk("idle_pts", 32'(addPoints), 32'd0);
        if (mon_prev) begin
          mon_low  = 1;
          mon_pend = (sb.size() > 0);
        end else mon_low++;
      end
      mon_prev = fromGame[0];
    end
  end

  // called and returns at posedge+2
  task automatic push(input logic [2:0] p);
    int occ;
    occ = sb.size() + int'(fromGame[0]);
    chk("ev_ready", 32'(ev_ready), 32'(occ < DEPTH));
    if (p != 0) begin
      if (occ < DEPTH) sb.push_back(p);
      else begin
        exp_ovf = 1'b1;
        exp_drops++;
      end
    end
    ev_valid  = 1'b1;
    ev_points = p;
    @(posedge clock); #2;
    ev_valid  = 1'b0;
    ev_points = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic wait_high(output int n);
    for (n = 0; n < 300; n++) begin
      if (fromGame[0]) break;
      @(posedge clock); #2;
    end
    chk("post_seen", 32'(fromGame[0]), 32'd1);
  endtask

  task automatic wait_low(output int n);
    for (n = 0; n < 300; n++) begin
      if (!fromGame[0]) break;
      @(posedge clock); #2;
    end
    chk("post_released", 32'(fromGame[0]), 32'd0);
  endtask

  task automatic toggle_ack();
    r1[0] = ~r1[0];
  endtask

  task automatic serve(input int hold);
    int n;
    wait_high(n);
    repeat (hold) begin @(posedge clock); #2; end
    toggle_ack();
    wait_low(n);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ovf"}, 32'(ev_overflow), 32'(exp_ovf));
    chk({tag, "_to"}, 32'(ack_timeout), 32'(exp_to));
`ifdef GAME_EVENT_STATS_EN
    chk({tag, "_drops"}, 32'(ev_drop_count), 32'(exp_drops));
`endif
  endtask

  initial begin
    int n;
    #3;
    chk("rst_fromGame", 32'(fromGame), 32'd0);
    chk("rst_addPoints", 32'(addPoints), 32'd0);
    chk("rst_level", 32'(cpu_level), 32'd0);
    check_flags("rst");
    @(posedge clock); @(posedge clock); #2;
    ctrl_reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ev_ready), 32'd1);
    idle(1);

    // single event plus a zero-valued event that must vanish silently
    push(3'd0);
    idle(2);
    push(3'd3);
    wait_high(n);
    chk("latency", n, 2);
    idle(5);
    chk("held_strobe", 32'(fromGame[0]), 32'd1);
    chk("held_pts", 32'(addPoints), 32'd3);
    toggle_ack();
    wait_low(n);
    chk("ack_latency", n, 1);
    idle(12);
    chk("single_empty", 32'(ev_ready), 32'd1);
    check_flags("single");

    // ack arriving on the timeout cycle counts as an ack
    push(3'd5);
    wait_high(n);
    repeat (TMO - 1) begin @(posedge clock); #2; end
    toggle_ack();
    wait_low(n);
    chk("ack_at_tmo_len", n, 1);
    idle(GAP + 2);
    check_flags("ack_at_tmo");

    // ordering with a full queue
    push(3'd1); push(3'd2); push(3'd4); push(3'd7);
    chk("full_ready", 32'(ev_ready), 32'd0);
    for (int i = 0; i < 4; i++) serve(2);
    idle(GAP + 2);
    chk("order_r1", 32'(r1[0]), 32'd0);
    check_flags("order");

    // overflow: fifth event with no ack is dropped
    push(3'd1); push(3'd2); push(3'd3); push(3'd4); push(3'd5);
    check_flags("overflow");
    for (int i = 0; i < 4; i++) serve(1);
    idle(GAP + 2);

    // timeout: never ack the first event
    push(3'd6); push(3'd2);
    wait_high(n);
    wait_low(n);
    chk("tmo_hold_cycles", n, TMO);
    exp_to = 1'b1;
    exp_drops++;
    @(negedge clock);
    check_flags("timeout");
    serve(2);
    idle(GAP + 2);

    // game-over latch
    game_over = 1'b1; idle(1); game_over = 1'b0;
    chk("go_set", 32'(fromGame[1]), 32'd1);
    r1[1] = 1'b1; idle(1);
    chk("go_clear", 32'(fromGame[1]), 32'd0);
    r1[1] = 1'b0; idle(1);
    game_over = 1'b1; idle(1); game_over = 1'b0;
    chk("go_set2", 32'(fromGame[1]), 32'd1);
    r1[1] = 1'b0; idle(1);
    game_over = 1'b1; r1[1] = 1'b1; idle(1); game_over = 1'b0;
    chk("go_set_wins", 32'(fromGame[1]), 32'd1);
    idle(1);
    chk("go_no_edge", 32'(fromGame[1]), 32'd1);
    r1[1] = 1'b0; idle(1);
    r1[1] = 1'b1; idle(1);
    chk("go_clear2", 32'(fromGame[1]), 32'd0);
    r1[1] = 1'b0;

    // level / pause mirrors
    r1[15:8] = 8'h5A; r1[2] = 1'b1; idle(1);
    chk("level_a", 32'(cpu_level), 32'h5A);
    chk("pause_a", 32'(cpu_pause), 32'd1);
    r1[15:8] = 8'h03; r1[2] = 1'b0; idle(1);
    chk("level_b", 32'(cpu_level), 32'h03);
    chk("pause_b", 32'(cpu_pause), 32'd0);

    // reset during WAIT_ACK with two events still queued
    game_over = 1'b1; idle(1); game_over = 1'b0;
    push(3'd1); push(3'd2); push(3'd3);
    wait_high(n);
    ctrl_reset = 1'b1;
    #1;
    chk("mid_rst_fromGame", 32'(fromGame), 32'd0);
    chk("mid_rst_addPoints", 32'(addPoints), 32'd0);
    chk("mid_rst_level", 32'(cpu_level), 32'd0);
    sb.delete();
    exp_ovf = 1'b0;
    exp_to = 1'b0;
    exp_drops = 0;
    check_flags("mid_rst");
    @(posedge clock); @(posedge clock); #2;
    ctrl_reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ev_ready), 32'd1);
    idle(30);
    chk("post_rst_quiet", 32'(fromGame[0]), 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/game_event_bridge.md
Name: game_event_bridge

Overview:
- Game-side counterpart of the processor register file's game side-channel.
- Queues scoring events from the Tetris game logic and posts them into CPU register r29 via `addPoints`/`fromGame[0]`, then waits for the CPU to acknowledge.
- Decodes the CPU mailbox register r1 (`data_readReg1`) into acknowledge, pause, level and game-over-clear controls for the game.
- Sits between the game logic and the register file, on the same clock.

Parameters:
- `FIFO_DEPTH`, 4, event queue entries; power of 2, minimum 2.
- `TIMEOUT_CYCLES`, 1000000, maximum cycles spent in WAIT_ACK before the event is abandoned.
- `GAP_CYCLES`, 8, idle cycles after each acknowledge or timeout before the next post.

Ports:
- `clock` input 1: system clock, rising edge.
- `ctrl_reset` input 1: asynchronous, active-high reset.
- `ev_valid` input 1: game event strobe, single-cycle; the source never retries.
- `ev_points` input 3: points value of the event.
- `ev_ready` output 1: queue can accept an event this cycle.
- `game_over` input 1: game-over pulse from the game logic.
- `addPoints` output 3: value posted to r29.
- `fromGame` output 2: bit0 = post strobe to r29; bit1 = latched game-over flag.
- `data_readReg1` input 32: live contents of CPU r1.
- `cpu_level` output 8: registered copy of r1[15:8].
- `cpu_pause` output 1: registered copy of r1[2].
- `ev_overflow` output 1: sticky flag, an event was lost.
- `ack_timeout` output 1: sticky flag, a post timed out.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; `ack_ref`=0; `ev_ready`=1 once reset is released.
- Push:
  - `ev_valid && ev_ready && ev_points!=0` enqueues `ev_points`.
  - `ev_points==0` is discarded silently and is not an overflow.
  - `ev_ready = !full`.
  - `ev_valid` with `ev_ready`=0 is dropped and sets `ev_overflow`.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- FSM states: IDLE, POST, WAIT_ACK, GAP.
  - IDLE: if FIFO not empty, go to POST next cycle.
  - POST (1 cycle): `addPoints`<=head; `fromGame[0]`<=1; `ack_ref`<=`data_readReg1[0]`; `timer`<=0; go to WAIT_ACK.
  - WAIT_ACK: keep `fromGame[0]`=1 and `addPoints` stable. The regfile reloads r29 on every cycle without a CPU write, so a colliding CPU write cannot lose the value.
    - Ack when `data_readReg1[0] != ack_ref`: pop the FIFO, go to GAP.
    - Timeout when `timer==TIMEOUT_CYCLES-1` with no ack: pop (discard the event), set `ack_timeout`, go to GAP.
    - Ack and timeout in the same cycle: treat as ack; `ack_timeout` is not set.
  - GAP: `fromGame[0]`=0 and `addPoints`=0 for exactly `GAP_CYCLES` cycles, then go to IDLE.
    - Zero-valued `addPoints` never reaches r29, because `fromGame[0]`=0 whenever `addPoints`=0.
- Posting latency: event accepted into an empty FIFO in cycle N → `fromGame[0]` rises with the clock edge ending cycle N+2 (IDLE evaluates at N+1, POST registers at N+2).
- Firmware contract (CPU side):
  - poll r29 != 0; read it; toggle r1[0];
  - write r29=0 within `GAP_CYCLES` cycles of the toggle.
- `fromGame[1]`:
  - set by a `game_over` pulse;
  - cleared on a rising edge of r1[1], detected with a registered previous value;
  - set and clear in the same cycle: set wins.
- `cpu_level` and `cpu_pause`: one-cycle registered copies of r1. They have no effect on the FSM.
- Sticky flags clear only on reset.
- Timer is 32 bits wide and resets on every entry to POST.
- Reset asserted mid-operation: FSM returns to IDLE and the queued events are lost; `fromGame` goes to 0 asynchronously.

Optional Feature:
- Macro: `GAME_EVENT_STATS_EN`.
- Defined: adds output `ev_drop_count` (16 bits).
  - Increments on each overflow drop and each timeout; saturates at 0xFFFF; reset to 0.
  - Overflow and timeout in the same cycle: increments by 2, saturating.
- Undefined: port absent; counter logic not present; all other behaviour identical.

Test Plan:
- Single event: reset, r1=0, push `ev_points`=3 → `fromGame[0]`=1 and `addPoints`=3 in the POST cycle; held until r1[0]=1; then 8 cycles of 0; FIFO empty.
- Queue ordering: push 1, 2, 4, 7 back-to-back with `FIFO_DEPTH`=4 → `ev_ready` low after the 4th push; posts arrive in order 1, 2, 4, 7, each released by a toggle of r1[0] (1, 0, 1, 0).
- Overflow: push 5 events with no ack → 5th dropped; `ev_overflow`=1; with `GAME_EVENT_STATS_EN`, `ev_drop_count`=1.
- Timeout: `TIMEOUT_CYCLES`=16, push 6, never toggle r1[0] → `fromGame[0]` held for 16 WAIT_ACK cycles; `ack_timeout`=1; event discarded; next event posts after GAP.
- Game-over: `game_over` pulse → `fromGame[1]`=1; r1[1] 0→1 → cleared one cycle later; `game_over` pulse coinciding with the r1[1] rise → stays 1.
- Reset mid-WAIT_ACK with 2 events queued → all outputs 0 immediately; after release, `ev_ready`=1 and nothing is posted.
